// File: rtl/pool2d_stream.sv
// rtl/pool2d_stream.sv - streaming POOL x POOL pooling over a raster-order pixel stream
// Define POOL_AVG_EN to build the runtime average mode; without it the block is max-only.
module pool2d_stream #(
    parameter int WIDTH_BIT = 16,
    parameter int IMG_W     = 254,
    parameter int IMG_H     = 254,
    parameter int POOL      = 2,
    parameter int STRIDE    = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH_BIT-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH_BIT-1:0] out_data,
    output logic                 out_last,
    output logic                 done
);
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int PW    = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int OUT_W = (IMG_W - POOL) / STRIDE + 1;
    localparam int OUT_H = (IMG_H - POOL) / STRIDE + 1;

    localparam logic [CW-1:0] COL_MAX   = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(POOL - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'((OUT_W - 1) * STRIDE + POOL - 1);
    localparam logic [RW-1:0] ROW_MAX   = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(POOL - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'((OUT_H - 1) * STRIDE + POOL - 1);
    localparam logic [PW-1:0] PH_MAX    = PW'(STRIDE - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [PW-1:0] cph;
    logic [PW-1:0] rph;
    logic          fire;
    logic          complete;

    logic signed [WIDTH_BIT-1:0] lb  [POOL-1][IMG_W];
    logic signed [WIDTH_BIT-1:0] win [POOL][POOL];
    logic signed [WIDTH_BIT-1:0] wn  [POOL][POOL];
    logic signed [WIDTH_BIT-1:0] mx;
    logic signed [WIDTH_BIT-1:0] result;

    assign in_ready = !out_valid || out_ready;
    assign fire     = in_valid && in_ready;
    assign complete = fire && (col >= COL_FIRST) && (row >= ROW_FIRST) && (cph == '0) && (rph == '0);
    assign done     = out_valid && out_ready && out_last;

    // wn is the window as it will look after this pixel shifts in; row POOL-1 is the current row
    always_comb begin
        for (int r = 0; r < POOL; r++) begin
            for (int c = 0; c < POOL - 1; c++) begin
                wn[r][c] = win[r][c + 1];
            end
        end
        for (int r = 0; r < POOL - 1; r++) begin
            wn[r][POOL - 1] = lb[r][col];
        end
        wn[POOL - 1][POOL - 1] = in_data;
    end

    always_comb begin
        mx = wn[0][0];
        for (int r = 0; r < POOL; r++) begin
            for (int c = 0; c < POOL; c++) begin
                if (wn[r][c] > mx) mx = wn[r][c];
            end
        end
    end

`ifdef POOL_AVG_EN
    localparam int SH     = 2 * $clog2(POOL);
    localparam int SUM_W  = WIDTH_BIT + SH;
    localparam bit AVG_OK = ((POOL & (POOL - 1)) == 0);

    logic                    mode_q;
    logic signed [SUM_W-1:0] sum;

    // Arithmetic shift gives floor division; non-power-of-2 windows fall back to max
    always_comb begin
        sum = '0;
        for (int r = 0; r < POOL; r++) begin
            for (int c = 0; c < POOL; c++) begin
                sum = sum + SUM_W'(wn[r][c]);
            end
        end
        result = (mode_q && AVG_OK) ? WIDTH_BIT'(sum >>> SH) : mx;
    end
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign result      = mx;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col       <= '0;
            row       <= '0;
            cph       <= '0;
            rph       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
`ifdef POOL_AVG_EN
            mode_q    <= 1'b0;
`endif
        end else begin
            if (fire) begin
`ifdef POOL_AVG_EN
                if (col == '0 && row == '0) mode_q <= mode;
`endif
                if (col == COL_MAX) begin
                    col <= '0;
                    cph <= '0;
                    if (row == ROW_MAX) begin
                        row <= '0;
                        rph <= '0;
                    end else begin
                        row <= row + 1'b1;
                        rph <= (row + 1'b1 == ROW_FIRST || rph == PH_MAX) ? '0 : rph + 1'b1;
                    end
                end else begin
                    col <= col + 1'b1;
                    cph <= (col + 1'b1 == COL_FIRST || cph == PH_MAX) ? '0 : cph + 1'b1;
                end
            end
            if (complete) begin
                out_valid <= 1'b1;
                out_data  <= result;
                out_last  <= (col == COL_LAST) && (row == ROW_LAST);
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    // Line buffers and window carry no reset; the counters gate every use of stale contents
    always_ff @(posedge clock) begin
        if (fire) begin
            for (int r = 0; r < POOL; r++) begin
                for (int c = 0; c < POOL; c++) begin
                    win[r][c] <= wn[r][c];
                end
            end
            for (int j = 0; j < POOL - 2; j++) begin
                lb[j][col] <= lb[j + 1][col];
            end
            lb[POOL - 2][col] <= in_data;
        end
    end
endmodule

// File: tb/tb_pool2d_stream.sv
// tb/tb_pool2d_stream.sv - self-checking bench for pool2d_stream over five image geometries
module tb_pool2d_stream;
    localparam int NK = 5;
    localparam int GW [NK] = '{4, 4, 5, 7, 9};
    localparam int GH [NK] = '{4, 4, 5, 6, 7};
    localparam int GP [NK] = '{2, 2, 2, 3, 4};
    localparam int GS [NK] = '{2, 1, 2, 2, 3};

    logic        clock = 1'b0;
    logic        reset;
    logic        mode      [NK];
    logic        in_valid  [NK];
    logic        in_ready  [NK];
    logic [15:0] in_data   [NK];
    logic        out_valid [NK];
    logic        out_ready [NK];
    logic [15:0] out_data  [NK];
    logic        out_last  [NK];
    logic        done      [NK];

    always #5 clock = ~clock;

    for (genvar g = 0; g < NK; g++) begin : g_dut
        pool2d_stream #(
            .WIDTH_BIT(16), .IMG_W(GW[g]), .IMG_H(GH[g]), .POOL(GP[g]), .STRIDE(GS[g])
        ) u_dut (
            .clock(clock), .reset(reset), .mode(mode[g]),
            .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_data(in_data[g]),
            .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_data(out_data[g]),
            .out_last(out_last[g]), .done(done[g])
        );
    end

    typedef struct {
        int k;
        bit md;
        bit neg;
        int n;
        int ev [9];
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          act = 0;
    int          done_cnt = 0;
    bit          last_acc;
    bit          pv, pr, pl;
    logic [15:0] pd;
    int          pix [64];
    int          exp_v [$];
    int          exp_pi [$];
    int          got_d [$];
    int          got_cyc [$];
    int          pix_cyc [$];
    bit          got_last [$];
    bit          got_done [$];
    vec_t        tbl [6];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // One clock: observe the active instance at the falling edge, return just after the rising edge
    task automatic step();
        @(negedge clock);
        cyc++;
        last_acc = 1'b0;
        if (reset) begin
            pv = 1'b0;
        end else begin
            chk("in_ready_rule", int'(in_ready[act]), int'(!out_valid[act] || out_ready[act]));
            if (pv && !pr) begin
                chk("hold_valid", int'(out_valid[act]), 1);
                chk("hold_data", int'(out_data[act]), int'(pd));
                chk("hold_last", int'(out_last[act]), int'(pl));
            end
            if (in_valid[act] && in_ready[act]) begin
                last_acc = 1'b1;
                pix_cyc.push_back(cyc);
            end
            if (out_valid[act] && out_ready[act]) begin
                got_d.push_back(int'($signed(out_data[act])));
                got_cyc.push_back(cyc);
                got_last.push_back(out_last[act]);
                got_done.push_back(done[act]);
            end
            if (done[act]) done_cnt++;
            pv = out_valid[act];
            pr = out_ready[act];
            pd = out_data[act];
            pl = out_last[act];
        end
        @(posedge clock);
        #1;
    endtask

    task automatic fill(input int k, input int pat);
        for (int i = 0; i < 64; i++) pix[i] = 0;
        for (int i = 0; i < GW[k] * GH[k]; i++)
            pix[i] = (pat == 0) ? i : (pat == 2) ? int'($urandom_range(0, 65535)) - 32768 : 0;
        if (pat == 1) begin
            pix[0] = -1;
            pix[1] = -2;
            pix[GW[k]] = -3;
            pix[GW[k] + 1] = -4;
        end
    endtask

    // Reference: enumerate output windows directly from image geometry
    task automatic model(input int k, input bit fmode);
        int w, p, s, ow, oh, v, mx, sum, q, n2;
        bit use_avg;
        w = GW[k];
        p = GP[k];
        s = GS[k];
        ow = (w - p) / s + 1;
        oh = (GH[k] - p) / s + 1;
        n2 = p * p;
`ifdef POOL_AVG_EN
        use_avg = fmode && ((p & (p - 1)) == 0);
`else
        use_avg = 1'b0;
`endif
        exp_v.delete();
        exp_pi.delete();
        for (int oy = 0; oy < oh; oy++) begin
            for (int ox = 0; ox < ow; ox++) begin
                mx = -2147483647;
                sum = 0;
                for (int dy = 0; dy < p; dy++) begin
                    for (int dx = 0; dx < p; dx++) begin
                        v = pix[(oy * s + dy) * w + ox * s + dx];
                        if (v > mx) mx = v;
                        sum += v;
                    end
                end
                q = sum / n2;
                if ((sum % n2) != 0 && sum < 0) q--;
                exp_v.push_back(use_avg ? q : mx);
                exp_pi.push_back((oy * s + p - 1) * w + ox * s + p - 1);
            end
        end
    endtask

    // bp: 0 = always ready, 1 = random ready, 2 = one 5-cycle stall on the first output
    task automatic run_frame(input int k, input bit fmode, input int bp, input bit check_lat,
                             output int g0);
        int n, idx, budget, p0, d0, stall, last_i;
        bit stalled, stall_now;
        n = GW[k] * GH[k];
        model(k, fmode);
        act = k;
        g0 = got_d.size();
        p0 = pix_cyc.size();
        d0 = done_cnt;
        idx = 0;
        budget = 0;
        stall = 0;
        stalled = 1'b0;
        while (idx < n && budget < 4000) begin
            mode[k] = (idx == 0) ? fmode : 1'($urandom_range(0, 1));
            in_data[k] = 16'(pix[idx]);
            in_valid[k] = (bp == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (bp == 2 && !stalled && out_valid[k]) begin
                stall = 5;
                stalled = 1'b1;
            end
            stall_now = (stall > 0);
            if (bp == 1) out_ready[k] = ($urandom_range(0, 2) != 0);
            else out_ready[k] = !stall_now;
            if (stall_now) stall--;
            step();
            if (stall_now) begin
                chk("stall_in_ready", int'(in_ready[k]), 0);
                chk("stall_out_valid", int'(out_valid[k]), 1);
            end
            if (last_acc) idx++;
            budget++;
        end
        chk("inputs_accepted", idx, n);
        in_valid[k] = 1'b0;
        out_ready[k] = 1'b1;
        budget = 0;
        while (got_d.size() - g0 < exp_v.size() && budget < 200) begin
            step();
            budget++;
        end
        repeat (3) step();
        chk("out_count", got_d.size() - g0, exp_v.size());
        last_i = exp_v.size() - 1;
        for (int i = 0; i < exp_v.size() && g0 + i < got_d.size(); i++) begin
            chk("out_data", got_d[g0 + i], exp_v[i]);
            chk("out_last", int'(got_last[g0 + i]), int'(i == last_i));
            chk("done_on_accept", int'(got_done[g0 + i]), int'(i == last_i));
            if (check_lat && p0 + exp_pi[i] < pix_cyc.size())
                chk("latency", got_cyc[g0 + i] - pix_cyc[p0 + exp_pi[i]], 1);
        end
        chk("done_pulses", done_cnt - d0, 1);
    endtask

    initial begin
        int g0, k, acc, b;
        reset = 1'b0;
        for (int i = 0; i < NK; i++) begin
            mode[i] = 1'b0;
            in_valid[i] = 1'b0;
            in_data[i] = '0;
            out_ready[i] = 1'b1;
        end
        #1;
        reset = 1'b1;
        step();
        step();
        for (int i = 0; i < NK; i++) begin
            chk("rst_out_valid", int'(out_valid[i]), 0);
            chk("rst_out_data", int'(out_data[i]), 0);
            chk("rst_out_last", int'(out_last[i]), 0);
            chk("rst_done", int'(done[i]), 0);
            chk("rst_in_ready", int'(in_ready[i]), 1);
        end
        reset = 1'b0;
        step();

        tbl[0] = '{0, 1'b0, 1'b0, 4, '{5, 7, 13, 15, 0, 0, 0, 0, 0}};
        tbl[1] = '{1, 1'b0, 1'b0, 9, '{5, 6, 7, 9, 10, 11, 13, 14, 15}};
        tbl[3] = '{2, 1'b0, 1'b0, 4, '{6, 8, 16, 18, 0, 0, 0, 0, 0}};
        tbl[4] = '{0, 1'b0, 1'b1, 4, '{-1, 0, 0, 0, 0, 0, 0, 0, 0}};
`ifdef POOL_AVG_EN
        tbl[2] = '{0, 1'b1, 1'b0, 4, '{2, 4, 10, 12, 0, 0, 0, 0, 0}};
        tbl[5] = '{0, 1'b1, 1'b1, 4, '{-3, 0, 0, 0, 0, 0, 0, 0, 0}};
`else
        tbl[2] = '{0, 1'b1, 1'b0, 4, '{5, 7, 13, 15, 0, 0, 0, 0, 0}};
        tbl[5] = '{0, 1'b1, 1'b1, 4, '{-1, 0, 0, 0, 0, 0, 0, 0, 0}};
`endif
        for (int t = 0; t < 6; t++) begin
            fill(tbl[t].k, tbl[t].neg ? 1 : 0);
            run_frame(tbl[t].k, tbl[t].md, 0, 1'b1, g0);
            chk("tbl_count", got_d.size() - g0, tbl[t].n);
            for (int i = 0; i < tbl[t].n && g0 + i < got_d.size(); i++)
                chk("tbl_data", got_d[g0 + i], tbl[t].ev[i]);
        end

        fill(1, 2);
        run_frame(1, 1'($urandom_range(0, 1)), 2, 1'b0, g0);

        // Abandon a frame after 7 pixels, then a fresh frame must start at pixel (0,0)
        fill(0, 0);
        act = 0;
        mode[0] = 1'b0;
        out_ready[0] = 1'b1;
        acc = 0;
        b = 0;
        while (acc < 7 && b < 100) begin
            in_valid[0] = 1'b1;
            in_data[0] = 16'(pix[acc]);
            step();
            if (last_acc) acc++;
            b++;
        end
        chk("abort_pixels", acc, 7);
        in_valid[0] = 1'b0;
        reset = 1'b1;
        step();
        chk("midrst_out_valid", int'(out_valid[0]), 0);
        chk("midrst_out_last", int'(out_last[0]), 0);
        chk("midrst_in_ready", int'(in_ready[0]), 1);
        reset = 1'b0;
        step();
        run_frame(0, 1'b0, 0, 1'b1, g0);
        chk("post_rst_count", got_d.size() - g0, 4);
        if (g0 + 3 < got_d.size()) begin
            chk("post_rst_first", got_d[g0], 5);
            chk("post_rst_final", got_d[g0 + 3], 15);
        end

        for (int r = 0; r < 10; r++) begin
            k = r % NK;
            fill(k, 2);
            run_frame(k, 1'($urandom_range(0, 1)), (r < NK) ? 0 : 1, r < NK, g0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
